// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, N data bits LSB first,
// optional even parity, stop bit; reports good frames and errors.
module serial_frame_rx #(
  parameter int N         = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         S_IN,
  output logic [N-1:0] DATA_OUT,
  output logic         VALID,
  output logic         FRAME_ERR,
  output logic         BUSY,
  output logic [7:0]   FRAME_CNT
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [N-1:0]  shreg;
  logic          par_acc;
  logic          par_err;
  logic          good;
  logic          bad;

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    good     = 1'b0;
    bad      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!S_IN) state_nx = DATA;
      end
      DATA: begin
        if (cnt == CW'(N - 1))
          state_nx = PARITY_EN ? PARITY : STOP;
      end
      PARITY: begin
        state_nx = STOP;
      end
      STOP: begin
        if (S_IN) begin
          state_nx = IDLE;
          good     = !par_err;
          bad      = par_err;
        end else begin
          state_nx = WAIT_IDLE;
          bad      = 1'b1;
        end
      end
      WAIT_IDLE: begin
        // a 0 here is line noise, never a start bit
        if (S_IN) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt       <= '0;
      shreg     <= '0;
      par_acc   <= 1'b0;
      par_err   <= 1'b0;
      DATA_OUT  <= '0;
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
      BUSY      <= 1'b0;
      FRAME_CNT <= 8'd0;
    end else begin
      VALID     <= good;
      FRAME_ERR <= bad;
      BUSY      <= (state_nx != IDLE);
      if (good) begin
        DATA_OUT  <= shreg;
        FRAME_CNT <= FRAME_CNT + 8'd1;
      end
      case (state)
        IDLE: begin
          cnt     <= '0;
          par_acc <= 1'b0;
          par_err <= 1'b0;
        end
        DATA: begin
          shreg[cnt] <= S_IN;
          par_acc    <= par_acc ^ S_IN;
          cnt        <= cnt + CW'(1);
        end
        PARITY: begin
          par_err <= par_acc ^ S_IN;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx with a frame scoreboard
// checking data, count, result kind and latency.
module tb_serial_frame_rx;

  logic       Clock;
  logic       Reset;
  logic       S_IN;
  logic [7:0] DATA_OUT;
  logic       VALID;
  logic       FRAME_ERR;
  logic       BUSY;
  logic [7:0] FRAME_CNT;

  typedef struct {
    logic       err;
    logic [7:0] data;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic [7:0] exp_data;
  logic [7:0] exp_cnt;

  serial_frame_rx #(.N(8), .PARITY_EN(1'b1)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .S_IN     (S_IN),
    .DATA_OUT (DATA_OUT),
    .VALID    (VALID),
    .FRAME_ERR(FRAME_ERR),
    .BUSY     (BUSY),
    .FRAME_CNT(FRAME_CNT)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (!Reset && (VALID || FRAME_ERR)) begin
      exp_t e;
      check("pulse_exclusive", {31'd0, VALID & FRAME_ERR}, 32'd0);
      check("pulse_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("valid", {31'd0, VALID}, {31'd0, !e.err});
        check("frame_err", {31'd0, FRAME_ERR}, {31'd0, e.err});
        check("data_out", {24'd0, DATA_OUT}, {24'd0, e.data});
        check("frame_cnt", {24'd0, FRAME_CNT}, {24'd0, e.cnt});
        check("latency", cyc, e.cyc);
      end
    end
  end

  task automatic drive_bit(input logic b);
    @(negedge Clock);
    S_IN = b;
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic pflip,
                            input logic stop);
    exp_t e;
    logic p;
    p = (^d) ^ pflip;
    @(negedge Clock);
    S_IN = 1'b0;
    // start sampled at edge cyc+1; stop at 8 data + parity + 1 later
    e.cyc = cyc + 1 + 8 + 1 + 1;
    if (pflip || !stop) begin
      e.err  = 1'b1;
      e.data = exp_data;
      e.cnt  = exp_cnt;
    end else begin
      exp_data = d;
      exp_cnt  = exp_cnt + 8'd1;
      e.err    = 1'b0;
      e.data   = d;
      e.cnt    = exp_cnt;
    end
    sb.push_back(e);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(stop);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++)
      @(negedge Clock);
    @(negedge Clock);
    check("drain", sb.size(), 32'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_data"}, {24'd0, DATA_OUT}, 32'd0);
    check({tag, "_valid"}, {31'd0, VALID}, 32'd0);
    check({tag, "_err"}, {31'd0, FRAME_ERR}, 32'd0);
    check({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
    check({tag, "_cnt"}, {24'd0, FRAME_CNT}, 32'd0);
  endtask

  initial begin
    Reset    = 1'b1;
    S_IN     = 1'b1;
    exp_data = 8'h00;
    exp_cnt  = 8'h00;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check_reset_outs("reset");
    Reset = 1'b0;
    repeat (2) drive_bit(1'b1);

    send_frame(8'hA5, 1'b0, 1'b1);
    drain();
    send_frame(8'hA5, 1'b1, 1'b1);
    drain();

    send_frame(8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive_bit(1'b0);
      check("wait_busy", {31'd0, BUSY}, 32'd1);
    end
    drive_bit(1'b1);
    check("wait_busy_last0", {31'd0, BUSY}, 32'd1);
    drive_bit(1'b1);
    check("wait_exit_idle", {31'd0, BUSY}, 32'd0);
    drive_bit(1'b1);
    check("no_false_start", {31'd0, BUSY}, 32'd0);
    drain();

    send_frame(8'h01, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    drive_bit(1'b1);
    drain();

    @(negedge Clock);
    S_IN = 1'b0;
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    @(negedge Clock);
    Reset = 1'b1;
    S_IN  = 1'b1;
    @(negedge Clock);
    check_reset_outs("mid_reset");
    Reset    = 1'b0;
    exp_data = 8'h00;
    exp_cnt  = 8'h00;
    repeat (12) drive_bit(1'b1);
    check("after_reset_idle", {31'd0, BUSY}, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1);
    drain();
    check("post_reset_cnt", {24'd0, FRAME_CNT}, 32'd1);

    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset    = 1'b0;
    exp_data = 8'h00;
    exp_cnt  = 8'h00;
    for (int i = 0; i < 256; i++)
      send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1);
    drive_bit(1'b1);
    drain();
    check("wrap_cnt", {24'd0, FRAME_CNT}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
